// File: rtl/nic_tx_word_serializer.sv
// Serializes wide NIC Tx words {last, data, keep} into one TX FIFO entry per kept byte lane.
// Optional statistics counters are built when NIC_TX_SER_STATS_EN is defined.
module nic_tx_word_serializer #(
   parameter int unsigned IN_DATA_WIDTH  = 64,
   parameter int unsigned IN_KEEP_WIDTH  = IN_DATA_WIDTH / 8,
   parameter int unsigned IN_PIPE_WIDTH  = IN_DATA_WIDTH + IN_KEEP_WIDTH + 1,
   parameter int unsigned OUT_PIPE_WIDTH = 10
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [IN_PIPE_WIDTH-1:0]  NIC_TX_pipe_write_data,
   input  logic                      NIC_TX_pipe_write_req,
   output logic                      NIC_TX_pipe_write_ack,
   output logic [OUT_PIPE_WIDTH-1:0] TX_FIFO_pipe_write_data,
   output logic                      TX_FIFO_pipe_write_req,
   input  logic                      TX_FIFO_pipe_write_ack,
   output logic                      busy
`ifdef NIC_TX_SER_STATS_EN
   ,
   output logic [31:0]               tx_frame_count,
   output logic [31:0]               tx_byte_count
`endif
);

   localparam int unsigned LW = (IN_KEEP_WIDTH > 1) ? $clog2(IN_KEEP_WIDTH) : 1;

   typedef enum logic {IDLE, SER} state_t;

   state_t                   state_q;
   logic [IN_DATA_WIDTH-1:0] data_q;
   logic                     last_q;
   logic [IN_KEEP_WIDTH-1:0] mask_q;
   logic                     zlen_q;

   logic                     in_last;
   logic [IN_DATA_WIDTH-1:0] in_data;
   logic [IN_KEEP_WIDTH-1:0] in_keep;
   logic [LW-1:0]            cur;
   logic                     final_w;
   logic                     ser;
   logic                     accept;
   logic [7:0]               cur_byte;

   assign in_last = NIC_TX_pipe_write_data[IN_PIPE_WIDTH-1];
   assign in_data = NIC_TX_pipe_write_data[IN_PIPE_WIDTH-2:IN_KEEP_WIDTH];
   assign in_keep = NIC_TX_pipe_write_data[IN_KEEP_WIDTH-1:0];

   // Scan from the top so the lowest set lane wins.
   always_comb begin
      cur = '0;
      for (int unsigned i = IN_KEEP_WIDTH; i > 0; i--) begin
         if (mask_q[i-1]) cur = LW'(i - 1);
      end
   end

   assign final_w  = zlen_q | $onehot(mask_q);
   assign cur_byte = zlen_q ? 8'h00 : data_q[8*cur +: 8];
   assign ser      = reset & (state_q == SER);
   assign accept   = NIC_TX_pipe_write_req & NIC_TX_pipe_write_ack;

   assign busy                    = ser;
   assign TX_FIFO_pipe_write_req  = ser;
   assign TX_FIFO_pipe_write_data = ser ? {last_q & final_w, cur_byte, ~zlen_q} : '0;
   assign NIC_TX_pipe_write_ack   = reset & ((state_q == IDLE) |
                                             (final_w & TX_FIFO_pipe_write_ack));

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         data_q  <= '0;
         last_q  <= 1'b0;
         mask_q  <= '0;
         zlen_q  <= 1'b0;
      end else begin
         if (state_q == SER && TX_FIFO_pipe_write_ack) begin
            mask_q[cur] <= 1'b0;
            if (final_w) begin
               state_q <= IDLE;
               zlen_q  <= 1'b0;
            end
         end
         // A load in the same cycle as the final byte overrides the return to IDLE.
         if (accept) begin
            if (in_keep != '0) begin
               data_q  <= in_data;
               last_q  <= in_last;
               mask_q  <= in_keep;
               zlen_q  <= 1'b0;
               state_q <= SER;
            end else if (in_last) begin
               data_q  <= '0;
               last_q  <= 1'b1;
               mask_q  <= '0;
               zlen_q  <= 1'b1;
               state_q <= SER;
            end
         end
      end
   end

`ifdef NIC_TX_SER_STATS_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         tx_frame_count <= '0;
         tx_byte_count  <= '0;
      end else if (ser && TX_FIFO_pipe_write_ack) begin
         if (TX_FIFO_pipe_write_data[OUT_PIPE_WIDTH-1]) tx_frame_count <= tx_frame_count + 32'd1;
         if (TX_FIFO_pipe_write_data[0])                tx_byte_count  <= tx_byte_count + 32'd1;
      end
   end
`endif

endmodule
